// File: rtl/red_pitaya_pid2_meas.sv
// Windowed measurement of PID output and P/I/D terms: mean, min and max over 2^E samples,
// published through a two-stage pipeline with hold/overrun handling for coherent software reads.
module red_pitaya_pid2_meas #(
  parameter int DW   = 14,
  parameter int SEQW = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic signed [DW-1:0]   dat_i,
  input  logic signed [DW-1:0]   meas_p_i,
  input  logic signed [DW-1:0]   meas_i_i,
  input  logic signed [DW-1:0]   meas_d_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic                   hold_i,
  input  logic [3:0]             set_win_i,
  output logic signed [DW-1:0]   avg_o,
  output logic signed [DW-1:0]   avg_p_o,
  output logic signed [DW-1:0]   avg_i_o,
  output logic signed [DW-1:0]   avg_d_o,
  output logic signed [DW-1:0]   min_o,
  output logic signed [DW-1:0]   max_o,
  output logic                   valid_o,
  output logic                   ovr_o,
  output logic [SEQW-1:0]        win_cnt_o,
  output logic                   state_o
);

  localparam int AW = DW + 15;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
  state_t state;

  logic signed [AW-1:0] acc_x, acc_p, acc_i, acc_d;
  logic signed [DW-1:0] trk_min, trk_max;
  logic [14:0]          cnt;
  logic                 in_win;
  logic [3:0]           e_r;

  logic                 s1_v;
  logic signed [AW-1:0] s1_x, s1_p, s1_i, s1_d;
  logic signed [DW-1:0] s1_min, s1_max;
  logic [3:0]           s1_e;

  logic [3:0]           e_cur;
  logic [15:0]          mask16;
  logic                 last;
  logic signed [AW-1:0] nxt_x, nxt_p, nxt_i, nxt_d;
  logic signed [DW-1:0] nxt_min, nxt_max;

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] v);
    return {{15{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [DW-1:0] mean(input logic signed [AW-1:0] s,
                                                input logic [3:0] e);
    logic signed [AW-1:0] t;
    t = s >>> e;
    return t[DW-1:0];
  endfunction

  // The window exponent is taken live from set_win_i only on a window's first sample.
  always_comb begin
    e_cur   = in_win ? e_r : set_win_i;
    mask16  = (16'd1 << e_cur) - 16'd1;
    last    = (cnt == mask16[14:0]);
    nxt_x   = (in_win ? acc_x : '0) + sext(dat_i);
    nxt_p   = (in_win ? acc_p : '0) + sext(meas_p_i);
    nxt_i   = (in_win ? acc_i : '0) + sext(meas_i_i);
    nxt_d   = (in_win ? acc_d : '0) + sext(meas_d_i);
    nxt_min = (!in_win || (dat_i < trk_min)) ? dat_i : trk_min;
    nxt_max = (!in_win || (dat_i > trk_max)) ? dat_i : trk_max;
  end

  assign state_o = state;

  // valid_o is a one-cycle strobe with no backpressure: results are sampled when it is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      acc_x     <= '0;  acc_p <= '0;  acc_i <= '0;  acc_d <= '0;
      trk_min   <= '0;  trk_max <= '0;
      cnt       <= '0;  in_win  <= 1'b0;  e_r <= '0;
      s1_v      <= 1'b0;
      s1_x      <= '0;  s1_p <= '0;  s1_i <= '0;  s1_d <= '0;
      s1_min    <= '0;  s1_max <= '0;  s1_e <= '0;
      avg_o     <= '0;  avg_p_o <= '0;  avg_i_o <= '0;  avg_d_o <= '0;
      min_o     <= '0;  max_o   <= '0;
      valid_o   <= 1'b0;
      ovr_o     <= 1'b0;
      win_cnt_o <= '0;
    end else begin
      valid_o <= 1'b0;
      s1_v    <= 1'b0;
      state   <= en_i ? ACC : IDLE;

      // Stage 2 runs independently of the accumulator, so enable/clear never abort it.
      if (s1_v) begin
        if (hold_i) begin
          ovr_o <= 1'b1;
        end else begin
          avg_o     <= mean(s1_x, s1_e);
          avg_p_o   <= mean(s1_p, s1_e);
          avg_i_o   <= mean(s1_i, s1_e);
          avg_d_o   <= mean(s1_d, s1_e);
          min_o     <= s1_min;
          max_o     <= s1_max;
          valid_o   <= 1'b1;
          win_cnt_o <= win_cnt_o + 1'b1;
        end
      end
      if (clr_i) ovr_o <= 1'b0;

      if (!en_i || clr_i || last) begin
        acc_x   <= '0;  acc_p <= '0;  acc_i <= '0;  acc_d <= '0;
        trk_min <= '0;  trk_max <= '0;
        cnt     <= '0;
        in_win  <= 1'b0;
        if (en_i && !clr_i) begin
          s1_v   <= 1'b1;
          s1_x   <= nxt_x;  s1_p <= nxt_p;  s1_i <= nxt_i;  s1_d <= nxt_d;
          s1_min <= nxt_min;
          s1_max <= nxt_max;
          s1_e   <= e_cur;
        end
      end else begin
        acc_x   <= nxt_x;  acc_p <= nxt_p;  acc_i <= nxt_i;  acc_d <= nxt_d;
        trk_min <= nxt_min;
        trk_max <= nxt_max;
        cnt     <= cnt + 15'd1;
        in_win  <= 1'b1;
        e_r     <= e_cur;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pid2_meas.sv
// Directed bench for red_pitaya_pid2_meas: expected windows are queued at stimulus time and
// popped by a monitor on every valid_o; a second instance exercises the window counter wrap.
module tb_red_pitaya_pid2_meas;
  localparam int DW   = 14;
  localparam int SEQW = 16;
  localparam int W    = 6 * DW + SEQW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i, en_i, clr_i, hold_i;
  logic [3:0]           set_win_i;
  logic signed [DW-1:0] dat_i, meas_p_i, meas_i_i, meas_d_i;
  logic signed [DW-1:0] avg_o, avg_p_o, avg_i_o, avg_d_o, min_o, max_o;
  logic                 valid_o, ovr_o, state_o;
  logic [SEQW-1:0]      win_cnt_o;

  logic                 w_rst, w_en;
  logic signed [DW-1:0] w_dat, w_zero;
  logic signed [DW-1:0] w_avg, w_avg_p, w_avg_i, w_avg_d, w_min, w_max;
  logic                 w_valid, w_ovr, w_state;
  logic [SEQW-1:0]      w_win;

  red_pitaya_pid2_meas #(.DW(DW), .SEQW(SEQW)) dut (
    .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .meas_p_i(meas_p_i), .meas_i_i(meas_i_i),
    .meas_d_i(meas_d_i), .en_i(en_i), .clr_i(clr_i), .hold_i(hold_i), .set_win_i(set_win_i),
    .avg_o(avg_o), .avg_p_o(avg_p_o), .avg_i_o(avg_i_o), .avg_d_o(avg_d_o),
    .min_o(min_o), .max_o(max_o), .valid_o(valid_o), .ovr_o(ovr_o),
    .win_cnt_o(win_cnt_o), .state_o(state_o)
  );

  red_pitaya_pid2_meas #(.DW(DW), .SEQW(SEQW)) u_wrap (
    .clk_i(clk), .rst_i(w_rst), .dat_i(w_dat), .meas_p_i(w_zero), .meas_i_i(w_zero),
    .meas_d_i(w_zero), .en_i(w_en), .clr_i(1'b0), .hold_i(1'b0), .set_win_i(4'd0),
    .avg_o(w_avg), .avg_p_o(w_avg_p), .avg_i_o(w_avg_i), .avg_d_o(w_avg_d),
    .min_o(w_min), .max_o(w_max), .valid_o(w_valid), .ovr_o(w_ovr),
    .win_cnt_o(w_win), .state_o(w_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act, mon_exp;
  int n_checks  = 0;
  int n_fail    = 0;
  int exp_win   = 0;
  int w_seen    = 0;
  logic wrap_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int x, input int p, input int i, input int d);
    dat_i    = x[DW-1:0];
    meas_p_i = p[DW-1:0];
    meas_i_i = i[DW-1:0];
    meas_d_i = d[DW-1:0];
    tick();
  endtask

  task automatic push_exp(input int avg, input int p, input int i, input int d,
                          input int mn, input int mx);
    logic [SEQW-1:0] c;
    exp_win++;
    c = exp_win[SEQW-1:0];
    exp_q.push_back({avg[DW-1:0], p[DW-1:0], i[DW-1:0], d[DW-1:0], mn[DW-1:0], mx[DW-1:0], c});
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (valid_o) begin
        mon_act = {avg_o, avg_p_o, avg_i_o, avg_d_o, min_o, max_o, win_cnt_o};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got result %h, expected no update", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL window_result: got %h, expected %h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  // window counter wrap at E=0: one window per cycle, 65538 windows in total
  initial begin
    w_rst = 1'b1; w_en = 1'b0; w_dat = '0; w_zero = '0;
    repeat (2) @(posedge clk);
    #1;
    w_rst = 1'b0;
    w_en  = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      w_dat = k[DW-1:0];
      @(negedge clk);
      if (w_valid) begin
        w_seen++;
        if (w_seen == 65535) check("win_cnt_ffff", int'(w_win), 65535);
        if (w_seen == 65536) check("win_cnt_wrap", int'(w_win), 0);
      end
      @(posedge clk);
      #1;
    end
    w_en = 1'b0;
    check("wrap_valid_count", w_seen, 65538);
    wrap_done = 1'b1;
  end

  // driver
  initial begin
    rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; hold_i = 1'b0; set_win_i = '0;
    dat_i = '0; meas_p_i = '0; meas_i_i = '0; meas_d_i = '0;
    repeat (3) tick();
    check("rst_avg", int'(avg_o), 0);
    check("rst_min", int'(min_o), 0);
    check("rst_max", int'(max_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_ovr", int'(ovr_o), 0);
    check("rst_win_cnt", int'(win_cnt_o), 0);
    check("rst_state", int'(state_o), 0);
    rst_i = 1'b0;
    tick();

    // basic window, E=2
    en_i = 1'b1; set_win_i = 4'd2;
    samp(100, 1, -1, 0); samp(200, 2, -1, 0); samp(300, 3, -1, 0);
    push_exp(250, 2, -1, -1, 100, 400);
    samp(400, 4, -1, -1);
    check("state_acc", int'(state_o), 1);
    en_i = 1'b0;
    repeat (3) tick();
    check("state_idle", int'(state_o), 0);

    // floor rounding, E=1
    en_i = 1'b1; set_win_i = 4'd1;
    samp(5, -3, 0, 7);
    push_exp(-1, -4, 0, 7, -6, 5);
    samp(-6, -4, 0, 8);
    en_i = 1'b0;
    repeat (3) tick();

    // longest window at full-scale inputs, E=15
    en_i = 1'b1; set_win_i = 4'd15;
    push_exp(-8192, 8191, 8191, -1, -8192, -8192);
    for (int k = 0; k < 32768; k++) samp(-8192, 8191, 8191, -1);
    en_i = 1'b0;
    repeat (3) tick();

    // hold across window end
    hold_i = 1'b1; en_i = 1'b1; set_win_i = 4'd1;
    samp(1, 1, 1, 1); samp(2, 2, 2, 2);
    en_i = 1'b0;
    tick();
    hold_i = 1'b0;
    tick();
    check("hold_ovr_set", int'(ovr_o), 1);
    check("hold_avg_kept", int'(avg_o), -8192);
    check("hold_win_cnt", int'(win_cnt_o), 3);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    check("clr_ovr_clear", int'(ovr_o), 0);

    // clear mid-window, then a full window with a mid-window exponent change
    en_i = 1'b1; set_win_i = 4'd2;
    samp(50, 0, 0, 0); samp(60, 0, 0, 0);
    clr_i = 1'b1; samp(999, 5, 5, 5); clr_i = 1'b0;
    samp(10, 0, 0, 0);
    set_win_i = 4'd0;
    samp(10, 0, 0, 0); samp(10, 0, 0, 0);
    push_exp(10, 0, 0, 0, 10, 10);
    samp(10, 0, 0, 0);
    en_i = 1'b0;
    repeat (3) tick();

    // clear on the last sample suppresses the window
    en_i = 1'b1; set_win_i = 4'd2;
    samp(20, 0, 0, 0); samp(20, 0, 0, 0); samp(20, 0, 0, 0);
    clr_i = 1'b1; samp(20, 0, 0, 0); clr_i = 1'b0;
    en_i = 1'b0;
    repeat (3) tick();
    check("clr_last_win_cnt", int'(win_cnt_o), 4);
    check("clr_last_avg", int'(avg_o), 10);

    // asynchronous reset between edges
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_avg", int'(avg_o), 0);
    check("arst_max", int'(max_o), 0);
    check("arst_win_cnt", int'(win_cnt_o), 0);
    check("arst_state", int'(state_o), 0);
    tick();
    rst_i = 1'b0;
    exp_win = 0;

    // reset mid-window leaves no stale partial sums
    en_i = 1'b1; set_win_i = 4'd2;
    samp(77, 0, 0, 0); samp(88, 0, 0, 0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    samp(40, 0, 0, 0); samp(40, 0, 0, 0); samp(40, 0, 0, 0);
    push_exp(40, 0, 0, 0, 40, 40);
    samp(40, 0, 0, 0);
    en_i = 1'b0;
    repeat (3) tick();

    // E=0 ramp: every sample is a window, valid_o continuous
    en_i = 1'b1; set_win_i = 4'd0;
    for (int k = 0; k < 10; k++) begin
      push_exp(k, -k, 0, 0, k, k);
      samp(k, -k, 0, 0);
      if (k >= 1) check("ramp_valid", int'(valid_o), 1);
    end
    en_i = 1'b0;
    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);

    for (int k = 0; k < 70000 && !wrap_done; k++) tick();
    check("wrap_finished", int'(wrap_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
